// File: rtl/mux_2_1.sv
// 2:1 word selector: combinational output plus a clock-aligned registered copy.
// The registered copy clears asynchronously on rst_n low; the combinational path ignores clk and reset.
module mux_2_1 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             selector,
  output logic [WIDTH-1:0] output1,
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] output1_q
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_sel_q;

  // Plain ?: keeps the standard X-merge behaviour on an unknown selector.
  assign w_sel = selector ? input2 : input1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q <= '0;
    end else begin
      r_sel_q <= w_sel;
    end
  end

  assign output1   = w_sel;
  assign output1_q = r_sel_q;

endmodule

// File: tb/tb_mux_2_1.sv
// Self-checking bench for mux_2_1: directed literal cases plus randomized stimulus
// compared every cycle against a behavioural model.
module tb_mux_2_1;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] input1, input2;
  logic         selector;
  logic [W-1:0] output1, output1_q;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [W-1:0] sampled_q[$];

  mux_2_1 #(.WIDTH(W)) dut (
    .input1   (input1),
    .input2   (input2),
    .selector (selector),
    .output1  (output1),
    .clk      (clk),
    .rst_n    (rst_n),
    .output1_q(output1_q)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pick(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (s === 1'b1) return b;
    return a;
  endfunction

  // Model: the word chosen at each live rising edge; reset empties the history,
  // and an empty history means the registered output reads zero.
  always @(posedge clk or negedge rst_n) begin
    if (rst_n !== 1'b1) sampled_q.delete();
    else sampled_q.push_back(pick(selector, input1, input2));
  end

  function automatic logic [W-1:0] exp_q();
    if (sampled_q.size() == 0) return '0;
    return sampled_q[$];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_output1", output1, pick(selector, input1, input2));
      check("cyc_output1_q", output1_q, exp_q());
    end
    if (sampled_q.size() > 8) void'(sampled_q.pop_front());
  end

  initial begin
    rst_n = 1'b0;
    input1 = 16'h3524; input2 = 16'h5e81; selector = 1'b0;
    #1 check("sel_in1", output1, 16'h3524);
    check("reset_q", output1_q, 16'h0000);
    selector = 1'b1;
    #1 check("sel_in2", output1, 16'h5e81);
    selector = 1'b0;
    #1 check("sel_back", output1, 16'h3524);
    selector = 1'b1; input2 = 16'hd609;
    #1 check("data_change", output1, 16'hd609);
    input1 = 16'h1234;
    #1 check("in1_ignored", output1, 16'hd609);
    @(posedge clk) #1 check("q_held_in_reset", output1_q, 16'h0000);

    @(negedge clk);
    #1 rst_n = 1'b1; selector = 1'b1; input2 = 16'h5e81;
    #1 check("q_before_edge", output1_q, 16'h0000);
    @(posedge clk) #1 check("q_after_edge", output1_q, 16'h5e81);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_q", output1_q, 16'h0000);
    check("midrst_out", output1, 16'h5e81);
    @(posedge clk) #1 check("midrst_q_hold", output1_q, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b1; input2 = 16'h0bad;
    #1 check("release_q0", output1_q, 16'h0000);
    @(posedge clk) #1 check("release_reload", output1_q, 16'h0bad);

    @(negedge clk);
    #1 input1 = 16'hffff; input2 = 16'h0000; selector = 1'b0;
    #1 check("ext_sel0", output1, 16'hffff);
    selector = 1'b1;
    #1 check("ext_sel1", output1, 16'h0000);
    input1 = 16'h0000; input2 = 16'hffff;
    #1 check("ext_swap1", output1, 16'hffff);
    selector = 1'b0;
    #1 check("ext_swap0", output1, 16'h0000);
    @(posedge clk) #1 check("ext_q", output1_q, 16'h0000);

    cmp_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      input1 = W'($urandom);
      input2 = W'($urandom);
      selector = 1'($urandom);
      if ($urandom_range(19, 0) == 0) begin
        rst_n = 1'b0;
        #1 check("rnd_rst_q", output1_q, 16'h0000);
      end else begin
        rst_n = 1'b1;
        #1;
      end
      check("rnd_out", output1, selector ? input2 : input1);
      selector = ~selector;
      #1 check("rnd_toggle", output1, selector ? input2 : input1);
    end
    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
